mac_stream: RTL and testbench

Parametrised, pipelined multiply-accumulate engine for framed sample streams. Each accepted `in_a`/`in_b` pair is multiplied, and the product is summed into a frame accumulator. On the sample flagged `in_last` the engine emits the frame total, a sample count and an overflow flag, then starts the next frame with no dead cycle. It replaces the single-width, free-running multiply-accumulator in the arithmetic datapath, where frame-delimited dot products are needed.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/mac_mult_stage.sv | 58 +++++
 rtl/mac_stream.sv | 141 ++++++++++++++
 tb/tb_mac_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the framed multiply-accumulate engine.
// Contents: default widths, accumulator FSM state encodings and helpers that
// return the largest and smallest value representable at a given width and
// signedness. Helpers return 64 bits; callers truncate to their own width
// (widths up to 64 bits are supported).
package mac_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_ACC_W = 24;
  localparam int unsigned DEF_CNT_W = 16;

  // Accumulator FSM states
  typedef logic [0:0] mac_state_t;
  localparam mac_state_t ST_IDLE = 1'b0;
  localparam mac_state_t ST_ACC  = 1'b1;

  function automatic logic [63:0] sat_max(input int unsigned width, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) return ones >> (65 - width);  // 0111...1
    else           return ones >> (64 - width);  // 1111...1
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) return ~(ones >> (65 - width));  // low 'width' bits read 1000...0
    else           return '0;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of mac_stream: registered multiplier with valid/last tags.
// The product is formed at 2*IN_W bits and extended to ACC_W bits, sign- or
// zero-extended according to SIGNED.
// Ports:
//   clk, aclr            clock, synchronous active-high reset
//   in_valid, in_last    sample tags
//   in_a, in_b           operands
//   p                    registered, extended product
//   p_valid, p_last      registered tags
module mac_mult_stage #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_a,
  input  logic [IN_W-1:0]   in_b,
  input  logic              in_last,
  output logic [ACC_W-1:0]  p,
  output logic              p_valid,
  output logic              p_last
);

  localparam int unsigned PW = 2 * IN_W;

  logic [PW-1:0]    a_x, b_x, prod;
  logic [ACC_W-1:0] prod_ext;

  // Extending operands to full product width first makes the low PW bits of a
  // plain multiply correct for both unsigned and two's-complement operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = PW'($signed(in_a));
      b_x = PW'($signed(in_b));
    end else begin
      a_x = PW'(in_a);
      b_x = PW'(in_b);
    end
    prod = a_x * b_x;
    if (SIGNED != 0) prod_ext = ACC_W'($signed(prod));
    else             prod_ext = ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= in_valid;
      p_last  <= in_valid & in_last;
      if (in_valid) p <= prod_ext;
    end
  end

endmodule

// File: rtl/mac_stream.sv
// Pipelined multiply-accumulate engine for framed sample streams.
// Stage 1 (mac_mult_stage) registers the product; stage 2 accumulates it per
// frame and emits total, sample count and overflow on the last sample.
// Optional feature macro: MAC_SAT_EN -- when defined the accumulator clamps
// at its range limits; otherwise it wraps. Overflow is reported either way.
// Ports:
//   clk, aclr            clock, synchronous active-high reset
//   in_valid, in_a, in_b, in_last   sample input (no backpressure)
//   out_valid            one-cycle result strobe
//   out_acc, out_count, out_ovf     frame result, held until next strobe
//   busy                 frame open or product in flight
module mac_stream
  import mac_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_a,
  input  logic [IN_W-1:0]   in_b,
  input  logic              in_last,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              busy
);

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));
`endif

  logic [ACC_W-1:0] p;
  logic             p_valid, p_last;

  mac_mult_stage #(
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk      (clk),
    .aclr     (aclr),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .p        (p),
    .p_valid  (p_valid),
    .p_last   (p_last)
  );

  mac_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_d;
  logic [ACC_W-1:0] out_acc_d;
  logic [CNT_W-1:0] out_count_d;
  logic             out_ovf_d;

  logic [ACC_W:0]   sum_x;
  logic             add_ovf;
  logic [ACC_W-1:0] add_res;

  // One extra bit catches unsigned carry-out or signed sign overflow.
  always_comb begin
    if (SIGNED != 0) begin
      sum_x   = {acc_q[ACC_W-1], acc_q} + {p[ACC_W-1], p};
      add_ovf = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    end else begin
      sum_x   = {1'b0, acc_q} + {1'b0, p};
      add_ovf = sum_x[ACC_W];
    end
    add_res = sum_x[ACC_W-1:0];
`ifdef MAC_SAT_EN
    // A negative true sum (top bit set) can only occur when signed.
    if (add_ovf) add_res = (SIGNED != 0 && sum_x[ACC_W]) ? ACC_MIN : ACC_MAX;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_acc_d   = out_acc;
    out_count_d = out_count;
    out_ovf_d   = out_ovf;

    if (p_valid) begin
      if (state_q == ST_IDLE) begin
        // First sample of a frame: never carry anything from the previous one.
        acc_d = p;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = add_res;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end
      state_d = p_last ? ST_IDLE : ST_ACC;
      if (p_last) begin
        out_valid_d = 1'b1;
        out_acc_d   = acc_d;
        out_count_d = cnt_d;
        out_ovf_d   = ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_valid <= out_valid_d;
      out_acc   <= out_acc_d;
      out_count <= out_count_d;
      out_ovf   <= out_ovf_d;
    end
  end

  assign busy = (state_q == ST_ACC) | p_valid;

endmodule

// File: tb/tb_mac_stream.sv
// Self-checking bench for mac_stream. Three instances share one stimulus bus:
// default unsigned, SIGNED=1, and ACC_W=16. A scoreboard queue holds expected
// frame results for the instance under test; a negedge monitor pops them.
module tb_mac_stream;

  logic       clk = 1'b0;
  logic       aclr;
  logic       in_valid, in_last;
  logic [7:0] in_a, in_b;

  logic        d0_valid, d0_ovf, d0_busy;
  logic [23:0] d0_acc;
  logic [15:0] d0_cnt;
  logic        d1_valid, d1_ovf, d1_busy;
  logic [23:0] d1_acc;
  logic [15:0] d1_cnt;
  logic        d2_valid, d2_ovf, d2_busy;
  logic [15:0] d2_acc;
  logic [15:0] d2_cnt;

  always #5 clk = ~clk;

  mac_stream u_d0 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(d0_valid), .out_acc(d0_acc), .out_count(d0_cnt),
    .out_ovf(d0_ovf), .busy(d0_busy)
  );

  mac_stream #(.SIGNED(1)) u_d1 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(d1_valid), .out_acc(d1_acc), .out_count(d1_cnt),
    .out_ovf(d1_ovf), .busy(d1_busy)
  );

  mac_stream #(.ACC_W(16)) u_d2 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(d2_valid), .out_acc(d2_acc), .out_count(d2_cnt),
    .out_ovf(d2_ovf), .busy(d2_busy)
  );

  typedef struct {
    logic [23:0] acc;
    logic [15:0] cnt;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   sel = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        o_valid, o_ovf, o_busy;
  logic [23:0] o_acc;
  logic [15:0] o_cnt;

  always_comb begin
    o_valid = d0_valid; o_acc = d0_acc; o_cnt = d0_cnt; o_ovf = d0_ovf; o_busy = d0_busy;
    if (sel == 1) begin
      o_valid = d1_valid; o_acc = d1_acc; o_cnt = d1_cnt; o_ovf = d1_ovf; o_busy = d1_busy;
    end else if (sel == 2) begin
      o_valid = d2_valid; o_acc = {8'h00, d2_acc}; o_cnt = d2_cnt; o_ovf = d2_ovf;
      o_busy = d2_busy;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid dut=%0d cyc=%0d acc=%h (no result expected)",
                 sel, cyc, o_acc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 3;
        if (o_acc !== e.acc) begin
          errors++;
          $display("FAIL out_acc dut=%0d got=%h want=%h", sel, o_acc, e.acc);
        end
        if (o_cnt !== e.cnt) begin
          errors++;
          $display("FAIL out_count dut=%0d got=%0d want=%0d", sel, o_cnt, e.cnt);
        end
        if (o_ovf !== e.ovf) begin
          errors++;
          $display("FAIL out_ovf dut=%0d got=%b want=%b", sel, o_ovf, e.ovf);
        end
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency dut=%0d got_cyc=%0d want_cyc=%0d", sel, cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic last);
    @(posedge clk);
    #1;
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = last;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Called right after driving a last sample: result due two cycles later.
  task automatic expect_frame(input logic [23:0] acc, input logic [15:0] cnt, input logic ovf);
    exp_t e;
    e.acc = acc; e.cnt = cnt; e.ovf = ovf; e.cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_timeout dut=%0d pending=%0d want=0", sel, exp_q.size());
      exp_q.delete();
    end
    repeat (3) idle();  // lets the monitor catch stray strobes
  endtask

  task automatic test_reset();
    aclr = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks += 5;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid dut=%0d got=%b want=0", s, o_valid); end
      if (o_acc !== 24'h0) begin errors++; $display("FAIL rst_acc dut=%0d got=%h want=0", s, o_acc); end
      if (o_cnt !== 16'h0) begin errors++; $display("FAIL rst_count dut=%0d got=%h want=0", s, o_cnt); end
      if (o_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf dut=%0d got=%b want=0", s, o_ovf); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy dut=%0d got=%b want=0", s, o_busy); end
    end
    sel = 0;
    @(posedge clk);
    #1 aclr = 1'b0;
  endtask

  task automatic test_frame3();
    sel = 0;
    drive(1'b1, 8'd3, 8'd4, 1'b0);
    drive(1'b1, 8'd5, 8'd6, 1'b0);
    drive(1'b1, 8'd7, 8'd8, 1'b1);
    expect_frame(24'd98, 16'd3, 1'b0);
    wait_drain();
    @(negedge clk);
    checks++;
    if (o_acc !== 24'd98) begin
      errors++;
      $display("FAIL acc_hold got=%0d want=98", o_acc);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    drive(1'b1, 8'd2, 8'd2, 1'b1);
    expect_frame(24'd4, 16'd1, 1'b0);
    drive(1'b1, 8'd1, 8'd1, 1'b0);
    drive(1'b1, 8'd10, 8'd10, 1'b1);
    expect_frame(24'd101, 16'd2, 1'b0);
    wait_drain();
  endtask

  task automatic test_signed();
    sel = 1;
    drive(1'b1, 8'hFD, 8'h04, 1'b0);  // -3 * 4
    drive(1'b1, 8'h02, 8'hFB, 1'b0);  // 2 * -5
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);  // -1 * -1
    expect_frame(24'hFFFFEB, 16'd3, 1'b0);  // -21
    wait_drain();
  endtask

  task automatic test_overflow();
    sel = 2;
    drive(1'b1, 8'd255, 8'd255, 1'b0);
    drive(1'b1, 8'd255, 8'd255, 1'b1);
`ifdef MAC_SAT_EN
    expect_frame(24'h00FFFF, 16'd2, 1'b1);
`else
    expect_frame(24'h00FC02, 16'd2, 1'b1);
`endif
    wait_drain();
    // Next frame must start with overflow cleared.
    drive(1'b1, 8'd1, 8'd1, 1'b1);
    expect_frame(24'd1, 16'd1, 1'b0);
    wait_drain();
  endtask

  task automatic test_gap();
    sel = 0;
    drive(1'b1, 8'd1, 8'd1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle();
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_busy idle=%0d got=%b want=1", g, o_busy);
      end
    end
    drive(1'b1, 8'd2, 8'd3, 1'b1);
    expect_frame(24'd7, 16'd2, 1'b0);
    wait_drain();
  endtask

  task automatic test_abort();
    sel = 0;
    drive(1'b1, 8'd4, 8'd4, 1'b0);
    drive(1'b1, 8'd5, 8'd5, 1'b0);
    drive(1'b1, 8'd6, 8'd6, 1'b0);  // dropped: same cycle as aclr
    aclr = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    aclr = 1'b0;
    @(negedge clk);
    checks += 3;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    if (o_acc !== 24'h0) begin errors++; $display("FAIL abort_out_acc got=%h want=0", o_acc); end
    if (o_cnt !== 16'h0) begin errors++; $display("FAIL abort_out_count got=%h want=0", o_cnt); end
    drive(1'b1, 8'd9, 8'd9, 1'b1);
    expect_frame(24'd81, 16'd1, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_frame3();
    test_back_to_back();
    test_signed();
    test_overflow();
    test_gap();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
